// File: rtl/xbar_defs.sv
// xbar_defs: shared helpers for the NxN crossbar.
// Provides the destination-width function dst_w(), the flit-slice macro
// `XBAR_SLICE(vec, k, w) and the "no valid index" marker XBAR_DST_INVALID.
`ifndef XBAR_DEFS_SV
`define XBAR_DEFS_SV
`define XBAR_SLICE(vec, k, w) vec[(k)*(w) +: (w)]
package xbar_defs;
    localparam int unsigned XBAR_DST_INVALID = 32'hFFFF_FFFF;
    function automatic int dst_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage
`endif

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, winner is first requester at or after ptr_i.
// Ports: req_i  [N]   request vector
//        ptr_i  [IW]  highest-priority index
//        en_i         grants are issued only when set
//        gnt_o  [N]   one-hot grant (zero when en_i=0 or no request)
//        gnt_idx_o    winner index, all-ones when nobody requests
module rr_arbiter
    import xbar_defs::*;
#(
    parameter int N = 5,
    localparam int IW = dst_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);
    logic found;
    int   j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = IW'(XBAR_DST_INVALID);
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_idx_o = IW'(j);
                gnt_o[j]  = en_i;
            end
        end
    end
endmodule

// File: rtl/nxn_arb_crossbar.sv
// nxn_arb_crossbar: NxN crossbar, round-robin per output, 1-cycle register slice per output.
// Ports: clk_i, rst_ni (async active-low)
//        data_i/dst_i/valid_i  flattened input flits, destinations, valids
//        ready_o               per-input grant (accepted this cycle)
//        data_o/valid_o        flattened registered output flits and valids
//        ready_i               downstream accept per output
//        last_i                packet tail flag per input (only with XBAR_PKT_LOCK_EN)
// Macro XBAR_PKT_LOCK_EN: lock an output to one input until that input's tail flit passes.
module nxn_arb_crossbar
    import xbar_defs::*;
#(
    parameter int DATA_W = 8,
    parameter int PORT_N = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [PORT_N*DATA_W-1:0]      data_i,
    input  logic [PORT_N*dst_w(PORT_N)-1:0] dst_i,
    input  logic [PORT_N-1:0]             valid_i,
    output logic [PORT_N-1:0]             ready_o,
`ifdef XBAR_PKT_LOCK_EN
    input  logic [PORT_N-1:0]             last_i,
`endif
    output logic [PORT_N*DATA_W-1:0]      data_o,
    output logic [PORT_N-1:0]             valid_o,
    input  logic [PORT_N-1:0]             ready_i
);
    localparam int DST_W = dst_w(PORT_N);

    logic [PORT_N-1:0] gnt [PORT_N];

    // Each input addresses a single output, so at most one gnt[o][i] is set per i.
    always_comb begin
        ready_o = '0;
        for (int o = 0; o < PORT_N; o++)
            for (int i = 0; i < PORT_N; i++)
                ready_o[i] = ready_o[i] | gnt[o][i];
    end

    for (genvar o = 0; o < PORT_N; o++) begin : g_out
        logic [PORT_N-1:0] req;
        logic [DST_W-1:0]  ptr, idx, ptr_nxt;
        logic [DATA_W-1:0] win, d_q;
        logic              v_q, load;
`ifdef XBAR_PKT_LOCK_EN
        logic              locked;
        logic [DST_W-1:0]  owner;
`endif

        assign load    = !v_q || ready_i[o];
        assign ptr_nxt = (idx == DST_W'(PORT_N - 1)) ? '0 : idx + DST_W'(1);
        assign valid_o[o] = v_q;
        assign `XBAR_SLICE(data_o, o, DATA_W) = d_q;

        // Out-of-range destinations never match any o, so such inputs never request.
        always_comb begin
            req = '0;
            for (int i = 0; i < PORT_N; i++) begin
                req[i] = valid_i[i] && (`XBAR_SLICE(dst_i, i, DST_W) == DST_W'(o));
`ifdef XBAR_PKT_LOCK_EN
                if (locked && DST_W'(i) != owner) req[i] = 1'b0;
`endif
            end
        end

        always_comb begin
            win = '0;
            for (int i = 0; i < PORT_N; i++)
                if (gnt[o][i]) win = `XBAR_SLICE(data_i, i, DATA_W);
        end

        rr_arbiter #(.N(PORT_N)) u_arb (
            .req_i     (req),
            .ptr_i     (ptr),
            .en_i      (load),
            .gnt_o     (gnt[o]),
            .gnt_idx_o (idx)
        );

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q    <= 1'b0;
                d_q    <= '0;
                ptr    <= '0;
`ifdef XBAR_PKT_LOCK_EN
                locked <= 1'b0;
                owner  <= '0;
`endif
            end else if (|gnt[o]) begin
                v_q <= 1'b1;
                d_q <= win;
`ifdef XBAR_PKT_LOCK_EN
                if (last_i[idx]) begin
                    ptr    <= ptr_nxt;
                    locked <= 1'b0;
                end else begin
                    locked <= 1'b1;
                    owner  <= idx;
                end
`else
                ptr <= ptr_nxt;
`endif
            end else if (ready_i[o]) begin
                v_q <= 1'b0;
            end
        end
    end
endmodule
